mem_bank_ctrl: RTL
==================

// Module: mem_bank_ctrl
// PURPOSE
//  Parametrised banked single-port memory with a command interface. It is the successor to the
//  fixed 4x1024x8 checker memory. The address is split into bank and row fields, and read
//  latency is configurable. It adds a hardware clear sequencer that sweeps all rows after reset
//  or on request, plus busy/valid/error status. It sits under the memory checker benches as the DUT.
// PARAMETERS
//  DATA_W   8   data width in bits
//  BANK_W   2   bank-select bits; BANKS = 2**BANK_W
//  ROW_W    10  row bits per bank; DEPTH = 2**ROW_W
//  RD_LAT   2   read latency in clk cycles, from command edge to dvalid (legal values 1..4)
// PORTS
//  clk     in   1               clock; all logic on the rising edge
//  rst_n   in   1               asynchronous reset, active low
//  cen     in   1               chip enable, active low; 1 = no command accepted
//  rd      in   1               read request (qualified by cen=0)
//  wr      in   1               write request (qualified by cen=0)
//  clr     in   1               start a clear sweep (qualified by cen=0)
//  add     in   BANK_W+ROW_W    address; add[MSB-:BANK_W] = bank, add[ROW_W-1:0] = row
//  din     in   DATA_W          write data
//  dout    out  DATA_W          read data; valid only while dvalid=1, otherwise 0
//  dvalid  out  1               one-cycle pulse per completed read
//  busy    out  1               1 while a clear sweep runs; commands are ignored
//  err     out  1               one-cycle pulse on an illegal command
// BEHAVIOUR
//  Reset (rst_n=0, async): dout=0, dvalid=0, err=0, busy=1, read pipe flushed, row counter=0,
//   FSM=CLEAR. The array contents are not reset directly; the sweep zeroes them.
//  FSM states:
//   CLEAR: each cycle writes 0 to row_cnt in all banks in parallel, then row_cnt++.
//          Goes to IDLE after the row_cnt=DEPTH-1 write, so a sweep lasts exactly DEPTH cycles.
//          busy=1 throughout CLEAR and falls on the edge that enters IDLE.
//   IDLE:  busy=0 and commands are decoded each rising edge. With cen=1 nothing is decoded.
//   The FSM enters CLEAR from IDLE when cen=0 and clr=1 (busy rises on the next edge).
//  Command priority in IDLE, cen=0:
//   1. clr=1 wins and rd/wr are ignored.
//   2. rd=1 & wr=1 is a no-op plus an err pulse on the next cycle.
//   3. wr=1 alone writes din to [bank][row] at that edge.
//   4. rd=1 alone samples [bank][row] at that edge.
//  Read timing: a read accepted at edge N drives dout and raises dvalid for one cycle starting
//   at edge N+RD_LAT-1, i.e. dvalid is seen high during cycle N+RD_LAT (RD_LAT=1 -> next cycle).
//   Reads are fully pipelined, one per cycle, and return in order.
//  Read-after-write: a read in the cycle after a write to the same address returns the new data.
//  Commands during busy: when cen=0 and (rd|wr) while busy=1, the command is dropped, err
//   pulses, and the array is not modified. clr during busy is ignored, with no err and no restart.
//  In-flight reads: reads already accepted when clr is taken still deliver their pre-clear data.
//  Reset mid-operation: a reset mid-sweep restarts the sweep from row 0. A reset kills in-flight
//   reads, so no dvalid is produced for them.
//  cen: deasserting cen does not cancel accepted reads.
//  Addressing: all address values are legal (power-of-two geometry); row_cnt wraps only at DEPTH.
//  err is a single-cycle pulse per offending edge; back-to-back errors give back-to-back pulses.
// TESTING (defaults unless stated)
//  1. Release rst_n. Expect busy=1 for exactly 1024 cycles, then 0. A read of 0xC05 then returns 0x00.
//  2. Write 0xA5 @0x3FF, then read 0x3FF on the next cycle. Expect dvalid 2 cycles after the read
//     edge with dout=0xA5. Separately, write 0x5A @0x7FF (bank1) and confirm @0x3FF still reads 0xA5.
//  3. Issue 4 back-to-back reads of 0x000..0x003 holding 0x10..0x13. Expect 4 consecutive dvalid
//     pulses carrying 0x10,0x11,0x12,0x13 in order. Repeat with RD_LAT=1 and RD_LAT=4.
//  4. Drive rd=wr=1 with cen=0: expect err for 1 cycle, no dvalid, memory unchanged. Drive wr
//     with cen=1: no write and no err.
//  5. Pulse clr; while busy, write 0xFF @0x123. Expect err and then 0x00 @0x123 after busy falls.
//     A read accepted the cycle before clr returns its old data.
//  6. Assert rst_n=0 at sweep row 500, then release: busy stays high for a full 1024 cycles,
//     and dout=0, dvalid=0 during reset.

Source files
------------

// File: rtl/mem_bank_ctrl.sv
// Banked single-port memory with command decode, pipelined reads and a clear sweeper.
// Latency: read data and dvalid appear RD_LAT cycles after the command edge; writes land at the command edge.
// Backpressure: none; commands arriving while busy are dropped and flagged on err.
module mem_bank_ctrl #(
    parameter int DATA_W = 8,
    parameter int BANK_W = 2,
    parameter int ROW_W  = 10,
    parameter int RD_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cen,
    input  logic                      rd,
    input  logic                      wr,
    input  logic                      clr,
    input  logic [BANK_W+ROW_W-1:0]   add,
    input  logic [DATA_W-1:0]         din,
    output logic [DATA_W-1:0]         dout,
    output logic                      dvalid,
    output logic                      busy,
    output logic                      err
);
    localparam int BANKS = 2 ** BANK_W;
    localparam int DEPTH = 2 ** ROW_W;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ROW_W-1:0]    row_cnt;
    logic [DATA_W-1:0]   mem [BANKS][DEPTH];
    logic [BANK_W-1:0]   bank;
    logic [ROW_W-1:0]    row;
    logic                cmd_ok;
    logic                rd_acc;
    logic                wr_acc;
    logic                err_nxt;
    logic [RD_LAT-1:0]   vld_pipe;
    logic [DATA_W-1:0]   dat_pipe [RD_LAT];

    assign bank    = add[BANK_W+ROW_W-1 -: BANK_W];
    assign row     = add[ROW_W-1:0];
    assign cmd_ok  = (state == IDLE) && !cen && !clr;
    assign rd_acc  = cmd_ok && rd && !wr;
    assign wr_acc  = cmd_ok && wr && !rd;
    // A clr during a sweep is silently ignored; only rd/wr while busy are errors.
    assign err_nxt = !cen && ((state == IDLE) ? (!clr && rd && wr) : (rd || wr));

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (row_cnt == {ROW_W{1'b1}}) state_nxt = IDLE;
            end
            IDLE: begin
                if (!cen && clr) state_nxt = CLEAR;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            row_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) row_cnt <= row_cnt + ROW_W'(1);
        end
    end

    // The array itself carries no reset; the sweep zeroes one row of every bank per cycle.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            for (int b = 0; b < BANKS; b++) mem[b][row_cnt] <= '0;
        end else if (wr_acc) begin
            mem[bank][row] <= din;
        end
    end

    // Data stages hold zero unless carrying a read, so dout is 0 whenever dvalid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) dat_pipe[i] <= '0;
            err <= 1'b0;
        end else begin
            vld_pipe[0] <= rd_acc;
            dat_pipe[0] <= rd_acc ? mem[bank][row] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
            err <= err_nxt;
        end
    end

    assign dvalid = vld_pipe[RD_LAT-1];
    assign dout   = dat_pipe[RD_LAT-1];
endmodule
